wb_rr_arbiter: RTL and testbench

N-port round-robin Wishbone classic-cycle master arbiter: multiplexes NPORTS single-word requesters (instruction fetch, data load/store, DMA, debug) onto one Wishbone bus between the MIPS core memory stages and the system bus. It generalises the two-port fetch/data arbiter in three ways: port count is a parameter, grant is fair round-robin and held for a full transaction by a registered FSM, and bus errors are returned per port. A compile-time watchdog can also terminate hung cycles.

---
 rtl/wb_rr_arbiter.sv | 176 +++++++++++++++++
 tb/tb_wb_rr_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_rr_arbiter.sv
// -----------------------------------------------------------------------------
// wb_rr_arbiter
//   Round-robin Wishbone classic-cycle master arbiter. NPORTS single-word
//   requesters share one Wishbone master port. A registered two-state FSM
//   (IDLE/BUSY) grants one port for a full transaction. Bus errors are
//   returned to the owning port.
//
//   Optional feature: define WB_ARB_TIMEOUT_EN to enable a watchdog. It
//   terminates a BUSY cycle with an error after TIMEOUT cycles without
//   ack/err.
//
// Ports
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_req/i_we          per-port request and write enable (NPORTS bits)
//   i_adr/i_sel/i_dat   per-port word address, byte selects, write data
//                       (port k at slice [k*W +: W])
//   o_dat               per-port registered read data
//   o_ack/o_err         per-port completion / error strobes
//   o_grant             one-hot current owner, zero when idle
//   o_wb_*              Wishbone master outputs (all zero unless BUSY)
//   i_wb_dat/ack/err    Wishbone slave responses
// -----------------------------------------------------------------------------
module wb_rr_arbiter #(
  parameter int unsigned NPORTS  = 2,
  parameter int unsigned AWIDTH  = 30,
  parameter int unsigned DWIDTH  = 32,
  parameter int unsigned TIMEOUT = 255,
  localparam int unsigned SELW   = DWIDTH / 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NPORTS-1:0]        i_req,
  input  logic [NPORTS-1:0]        i_we,
  input  logic [NPORTS*AWIDTH-1:0] i_adr,
  input  logic [NPORTS*SELW-1:0]   i_sel,
  input  logic [NPORTS*DWIDTH-1:0] i_dat,
  output logic [NPORTS*DWIDTH-1:0] o_dat,
  output logic [NPORTS-1:0]        o_ack,
  output logic [NPORTS-1:0]        o_err,
  output logic [NPORTS-1:0]        o_grant,
  output logic                     o_wb_cyc,
  output logic                     o_wb_stb,
  output logic                     o_wb_we,
  output logic [AWIDTH+1:0]        o_wb_adr,
  output logic [SELW-1:0]          o_wb_sel,
  output logic [DWIDTH-1:0]        o_wb_dat,
  input  logic [DWIDTH-1:0]        i_wb_dat,
  input  logic                     i_wb_ack,
  input  logic                     i_wb_err
);

  localparam int unsigned IW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam logic [IW-1:0] LAST_RST = IW'(NPORTS - 1);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e                   state_q, state_d;
  logic [NPORTS-1:0]        grant_q, grant_d;
  logic [IW-1:0]            last_q, last_d;
  logic [NPORTS*DWIDTH-1:0] dat_q, dat_d;
  logic                     tmo;
  logic [IW-1:0]            pick;
  logic                     pick_vld;
  logic [IW-1:0]            cand;

  // Round-robin search starting one past the last owner, wrapping around.
  // While BUSY, last_q is the index of the current owner.
  always_comb begin
    pick     = last_q;
    pick_vld = 1'b0;
    cand     = '0;
    for (int unsigned i = 1; i <= NPORTS; i++) begin
      cand = IW'((32'(last_q) + i) % NPORTS);
      if (!pick_vld && i_req[cand]) begin
        pick     = cand;
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    dat_d    = dat_q;
    o_ack    = '0;
    o_err    = '0;
    o_wb_cyc = 1'b0;
    o_wb_stb = 1'b0;
    o_wb_we  = 1'b0;
    o_wb_adr = '0;
    o_wb_sel = '0;
    o_wb_dat = '0;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          grant_d       = '0;
          grant_d[pick] = 1'b1;
          last_d        = pick;
          state_d       = BUSY;
        end
      end
      BUSY: begin
        o_wb_we  = i_we[last_q];
        o_wb_adr = {i_adr[last_q*AWIDTH +: AWIDTH], 2'b00};
        o_wb_sel = i_sel[last_q*SELW +: SELW];
        o_wb_dat = i_dat[last_q*DWIDTH +: DWIDTH];
        if (!i_req[last_q]) begin
          // Owner withdrew: drop the bus now and swallow any response.
          state_d = IDLE;
          grant_d = '0;
        end else begin
          o_wb_cyc = 1'b1;
          o_wb_stb = 1'b1;
          if (i_wb_err || tmo) begin
            o_err[last_q] = 1'b1;
            state_d       = IDLE;
            grant_d       = '0;
          end else if (i_wb_ack) begin
            o_ack[last_q]                    = 1'b1;
            dat_d[last_q*DWIDTH +: DWIDTH]   = i_wb_dat;
            state_d                          = IDLE;
            grant_d                          = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= LAST_RST;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      dat_q   <= dat_d;
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  logic [15:0] tcnt_q, tcnt_d;

  // Held at zero while idle so it starts from zero on entry to BUSY;
  // fires in the TIMEOUT-th BUSY cycle.
  always_comb begin
    tcnt_d = (state_q == BUSY) ? tcnt_q + 16'd1 : '0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tcnt_q <= '0;
    end else begin
      tcnt_q <= tcnt_d;
    end
  end

  assign tmo = (state_q == BUSY) && (tcnt_q == 16'(TIMEOUT - 1));
`else
  // TIMEOUT only matters when the watchdog is built in.
  logic unused_timeout;
  assign unused_timeout = ^32'(TIMEOUT);
  assign tmo            = 1'b0;
`endif

  assign o_grant = grant_q;
  assign o_dat   = dat_q;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
`timescale 1ns/1ps
module tb_wb_rr_arbiter;
  localparam int NP  = 4;
  localparam int AW  = 30;
  localparam int DW  = 32;
  localparam int SW  = 4;
  localparam int TMO = 4;

  logic clk = 1'b0;
  logic rst;
  logic [NP-1:0]    req, we;
  logic [NP*AW-1:0] adr;
  logic [NP*SW-1:0] sel;
  logic [NP*DW-1:0] wdat;
  logic [NP*DW-1:0] o_dat;
  logic [NP-1:0]    o_ack, o_err, o_grant;
  logic             cyc, stb, wwe;
  logic [AW+1:0]    wadr;
  logic [SW-1:0]    wsel;
  logic [DW-1:0]    wdo, wdi;
  logic             wack, werr;

  // slave model: 0=ack after slv_ws waits, 1=ack+err after slv_ws waits,
  // 2=never respond, 3=ack and err held high unconditionally
  int          slv_mode, slv_ws, wcnt;
  logic [31:0] slv_xor;
  logic        hit;

  int n_checks, n_errors, n_cpl, n_stb, cyc_cnt;
  int cpl_time [256];

  typedef struct {
    int            port;
    bit            err;
    logic [DW-1:0] dat;
  } exp_t;
  exp_t          sb [$];
  logic [DW-1:0] mdat [NP];
  logic [AW-1:0] badr [NP];

  wb_rr_arbiter #(.NPORTS(NP), .AWIDTH(AW), .DWIDTH(DW), .TIMEOUT(TMO)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req(req), .i_we(we), .i_adr(adr), .i_sel(sel), .i_dat(wdat),
    .o_dat(o_dat), .o_ack(o_ack), .o_err(o_err), .o_grant(o_grant),
    .o_wb_cyc(cyc), .o_wb_stb(stb), .o_wb_we(wwe), .o_wb_adr(wadr),
    .o_wb_sel(wsel), .o_wb_dat(wdo),
    .i_wb_dat(wdi), .i_wb_ack(wack), .i_wb_err(werr)
  );

  always #5 clk = ~clk;

  assign wdi  = slv_xor ^ {2'b00, wadr[AW+1:2]};
  assign wack = (slv_mode == 3) || ((slv_mode == 0 || slv_mode == 1) && stb && wcnt == slv_ws);
  assign werr = (slv_mode == 3) || (slv_mode == 1 && stb && wcnt == slv_ws);

  always @(posedge clk) begin
    hit = stb && !wack && !werr;
    #1;
    wcnt = hit ? wcnt + 1 : 0;
  end

  always @(posedge clk) cyc_cnt++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Completion monitor: pops the scoreboard on every ack/err strobe and
  // checks the read-data register one cycle later.
  bit            dpend;
  int            dport;
  logic [DW-1:0] dexp;
  exp_t          me;
  logic [NP-1:0] oh;
  always @(negedge clk) begin
    if (rst) begin
      dpend = 1'b0;
    end else begin
      if (stb) n_stb++;
      if (dpend) begin
        check("odat", o_dat[dport*DW +: DW], dexp);
        dpend = 1'b0;
      end
      if (|o_ack || |o_err) begin
        if (n_cpl < 256) cpl_time[n_cpl] = cyc_cnt;
        n_cpl++;
        if (sb.size() == 0) begin
          check("sb_unexpected", {o_ack, o_err}, 0);
        end else begin
          me = sb.pop_front();
          oh = '0;
          oh[me.port] = 1'b1;
          check("cpl_ack", o_ack, me.err ? '0 : oh);
          check("cpl_err", o_err, me.err ? oh : '0);
          check("cpl_grant", o_grant, oh);
          dport = me.port;
          dexp  = me.dat;
          dpend = 1'b1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic w, input logic [AW-1:0] a,
                          input logic [SW-1:0] s, input logic [DW-1:0] d);
    we[p]             = w;
    adr[p*AW +: AW]   = a;
    sel[p*SW +: SW]   = s;
    wdat[p*DW +: DW]  = d;
    badr[p]           = a;
  endtask

  task automatic expect_cpl(input int p, input bit err);
    exp_t e;
    e.port = p;
    e.err  = err;
    if (!err) mdat[p] = slv_xor ^ {2'b00, badr[p]};
    e.dat = mdat[p];
    sb.push_back(e);
  endtask

  task automatic wait_cpl(input int target, input string tag);
    for (int k = 0; k < 64 && n_cpl < target; k++) tick();
    check(tag, n_cpl, target);
  endtask

  task automatic txn(input int p, input logic w, input logic [AW-1:0] a,
                     input logic [SW-1:0] s, input logic [DW-1:0] d,
                     input int mode, input int nws);
    int c0, s0, exp_stb;
    slv_mode = mode;
    slv_ws   = nws;
    set_port(p, w, a, s, d);
    expect_cpl(p, mode != 0);
    exp_stb = (mode == 2) ? TMO : nws + 1;
    c0 = n_cpl;
    s0 = n_stb;
    req[p] = 1'b1;
    tick();
    check("bus_cyc", cyc, 1);
    check("bus_we", wwe, w);
    check("bus_adr", wadr, {a, 2'b00});
    check("bus_sel", wsel, s);
    check("bus_dat", wdo, d);
    wait_cpl(c0 + 1, "cpl_seen");
    req[p] = 1'b0;
    check("stb_cycles", n_stb - s0, exp_stb);
    tick();
    check("idle_cyc", cyc, 0);
    slv_mode = 0;
  endtask

  task automatic pair(input int pa, input int pb);
    int c0;
    slv_mode = 0;
    slv_ws   = 0;
    expect_cpl(pa, 1'b0);
    expect_cpl(pb, 1'b0);
    c0 = n_cpl;
    req[pa] = 1'b1;
    req[pb] = 1'b1;
    tick();
    check("pair_first", o_grant, NP'(1) << pa);
    wait_cpl(c0 + 1, "pair_cpl1");
    req[pa] = 1'b0;
    wait_cpl(c0 + 2, "pair_cpl2");
    req[pb] = 1'b0;
    tick();
  endtask

  initial begin
    int c0;
    rst = 1'b1; req = '0; we = '0; adr = '0; sel = '0; wdat = '0;
    slv_mode = 0; slv_ws = 0; slv_xor = '0; wcnt = 0; hit = 1'b0;
    n_checks = 0; n_errors = 0; n_cpl = 0; n_stb = 0; cyc_cnt = 0;
    for (int p = 0; p < NP; p++) begin
      mdat[p] = '0;
      badr[p] = '0;
    end
    repeat (3) tick();
    check("rst_grant", o_grant, 0);
    check("rst_cyc", cyc, 0);
    check("rst_stb", stb, 0);
    check("rst_we", wwe, 0);
    check("rst_adr", wadr, 0);
    check("rst_sel", wsel, 0);
    check("rst_wdat", wdo, 0);
    check("rst_ack", o_ack, 0);
    check("rst_err", o_err, 0);
    check("rst_odat", |o_dat, 0);
    rst = 1'b0;
    tick();

    // all four ports request continuously, zero-wait slave
    slv_xor = 32'h5A5A0000;
    for (int p = 0; p < NP; p++) set_port(p, 1'b0, AW'(30'h200 + p), 4'hF, '0);
    for (int r = 0; r < 6; r++) expect_cpl(r % NP, 1'b0);
    c0 = n_cpl;
    req = '1;
    wait_cpl(c0 + 6, "rr_done");
    req = '0;
    check("rr_spacing", cpl_time[c0 + 5] - cpl_time[c0], 10);
    tick();

    // single read, two wait states
    slv_xor = 32'hDEADBEEF ^ 32'h123;
    txn(0, 1'b0, 30'h123, 4'b1111, 32'h0, 0, 2);
    check("rd_deadbeef", o_dat[31:0], 32'hDEADBEEF);

    // write path
    slv_xor = 32'h0BAD0000;
    txn(1, 1'b1, 30'h100, 4'b0011, 32'h0000ABCD, 0, 0);
    check("wr_odat1", o_dat[63:32], 32'h0BAD0100);

    // err and ack together: err wins, read data untouched
    txn(0, 1'b0, 30'h55, 4'b0101, 32'h0, 1, 1);
    check("err_odat0", o_dat[31:0], 32'hDEADBEEF);

    // owner drops request mid-cycle
    slv_mode = 2;
    set_port(2, 1'b0, 30'h2AA, 4'hF, '0);
    req[2] = 1'b1;
    tick(); tick(); tick();
    check("abort_pre_stb", stb, 1);
    req[2]   = 1'b0;
    slv_mode = 3;
    #1;
    check("abort_stb", stb, 0);
    check("abort_cyc", cyc, 0);
    check("abort_ack", o_ack, 0);
    check("abort_err", o_err, 0);
    check("abort_grant", o_grant, 4'b0100);
    tick();
    check("abort_idle_grant", o_grant, 0);
    slv_mode = 0;

    // pointer stays at aborted port 2, so port 3 beats port 0
    pair(3, 0);

    // reset during an outstanding cycle
    slv_mode = 2;
    req[1] = 1'b1;
    tick(); tick();
    rst = 1'b1;
    req[1] = 1'b0;
    tick();
    check("mrst_cyc", cyc, 0);
    check("mrst_grant", o_grant, 0);
    check("mrst_odat", |o_dat, 0);
    rst = 1'b0;
    for (int p = 0; p < NP; p++) mdat[p] = '0;
    pair(0, 2);

`ifdef WB_ARB_TIMEOUT_EN
    txn(1, 1'b0, 30'h1F0, 4'hF, 32'h0, 2, 0);
    txn(2, 1'b0, 30'h0F1, 4'hF, 32'h0, 0, 1);
`endif

    tick();
    check("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
